// File: rtl/neuro_mac_if.sv
// Command, operand and result channels of the dot-product engine.
// The master side issues commands and operands; the slave side is the engine.
interface neuro_mac_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int LEN_W  = 5
);
   logic                     START;
   logic [LEN_W-1:0]         LEN;
   logic [1:0]               MODE;
   logic signed [ACC_W-1:0]  THRESH;
   logic                     IN_VALID;
   logic                     IN_READY;
   logic signed [DATA_W-1:0] IN_A;
   logic signed [DATA_W-1:0] IN_B;
   logic                     OUT_VALID;
   logic                     OUT_READY;
   logic signed [ACC_W-1:0]  OUT_DATA;
   logic                     OUT_SPIKE;
   logic                     BUSY;
   logic                     DONE;
   logic                     OVF;

   modport master (
      output START, LEN, MODE, THRESH, IN_VALID, IN_A, IN_B, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, OUT_SPIKE, BUSY, DONE, OVF
   );
   modport slave (
      input  START, LEN, MODE, THRESH, IN_VALID, IN_A, IN_B, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, OUT_SPIKE, BUSY, DONE, OVF
   );
endinterface

// File: rtl/neuro_mac_engine.sv
// Streaming signed dot product with saturating accumulator and a
// raw / ReLU / threshold-spike post-op, returned over valid/ready.
module neuro_mac_engine #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 24,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input logic        CLK,
   input logic        RESET,
   neuro_mac_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, POST, OUTPUT} state_t;

   localparam logic [LEN_W-1:0]        MAX_L   = LEN_W'(MAX_LEN);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   thresh;
   logic [1:0]                mode;
   logic [LEN_W-1:0]          count;
   logic [LEN_W-1:0]          eff_len;
   logic [LEN_W-1:0]          len_clamp;
   logic [LEN_W-1:0]          count_nxt;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W:0]     sum;
   logic signed [ACC_W:0]     diff;

   // One guard bit: overflow shows up as the top two bits disagreeing.
   function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
      if (v[ACC_W] != v[ACC_W-1]) return v[ACC_W] ? ACC_MIN : ACC_MAX;
      return $signed(v[ACC_W-1:0]);
   endfunction

   assign len_clamp = (bus.LEN > MAX_L) ? MAX_L : bus.LEN;
   assign count_nxt = count + 1'b1;
   assign prod      = bus.IN_A * bus.IN_B;
   assign sum       = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
   assign diff      = (ACC_W+1)'(acc) - (ACC_W+1)'(thresh);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state         <= IDLE;
         acc           <= '0;
         thresh        <= '0;
         mode          <= '0;
         count         <= '0;
         eff_len       <= '0;
         bus.IN_READY  <= 1'b0;
         bus.OUT_VALID <= 1'b0;
         bus.OUT_DATA  <= '0;
         bus.OUT_SPIKE <= 1'b0;
         bus.BUSY      <= 1'b0;
         bus.DONE      <= 1'b0;
         bus.OVF       <= 1'b0;
      end else begin
         bus.DONE <= 1'b0;
         case (state)
            IDLE: if (bus.START) begin
               mode     <= bus.MODE;
               thresh   <= bus.THRESH;
               acc      <= '0;
               count    <= '0;
               eff_len  <= len_clamp;
               bus.OVF  <= 1'b0;
               bus.BUSY <= 1'b1;
               if (len_clamp == '0) begin
                  state <= POST;
               end else begin
                  state        <= ACCUM;
                  bus.IN_READY <= 1'b1;
               end
            end
            ACCUM: if (bus.IN_VALID) begin
               acc   <= sat(sum);
               count <= count_nxt;
               if (sum[ACC_W] != sum[ACC_W-1]) bus.OVF <= 1'b1;
               if (count_nxt == eff_len) begin
                  state        <= POST;
                  bus.IN_READY <= 1'b0;
               end
            end
            POST: begin
               state         <= OUTPUT;
               bus.OUT_SPIKE <= 1'b0;
               bus.OUT_DATA  <= acc;
               if (mode == 2'b01 && acc[ACC_W-1]) begin
                  bus.OUT_DATA <= '0;
               end else if (mode == 2'b10 && acc >= thresh) begin
                  bus.OUT_SPIKE <= 1'b1;
                  bus.OUT_DATA  <= sat(diff);
                  if (diff[ACC_W] != diff[ACC_W-1]) bus.OVF <= 1'b1;
               end
            end
            OUTPUT: begin
               // First OUTPUT cycle raises valid; handshake is only taken once valid is up.
               if (!bus.OUT_VALID) begin
                  bus.OUT_VALID <= 1'b1;
               end else if (bus.OUT_READY) begin
                  bus.OUT_VALID <= 1'b0;
                  bus.DONE      <= 1'b1;
                  bus.BUSY      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
